// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues word fetches to a variable-latency memory,
// queues in-order responses for decode and squashes stale responses after a redirect.
module fetch_unit #(
  parameter int                    DATA_WIDTH      = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC        = '0,
  parameter int                    QUEUE_DEPTH     = 4,
  parameter int                    MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ready_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o,
  output logic [DATA_WIDTH-1:0] instr_pc_plus_4_o,
  input  logic                  instr_ready_i
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam int INF_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013);
  localparam logic [DATA_WIDTH-1:0] WORD_STEP  = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                  state_reg;
  logic [DATA_WIDTH-1:0]   fetch_pc_reg;
  logic [DATA_WIDTH-1:0]   ret_pc_reg;
  logic [PTR_W-1:0]        head_reg;
  logic [PTR_W-1:0]        tail_reg;
  logic [CNT_W-1:0]        count_reg;
  logic [INF_W-1:0]        inflight_reg;
  logic [INF_W-1:0]        drop_reg;
  logic [DATA_WIDTH-1:0]   q_instr [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0]   q_pc    [QUEUE_DEPTH];

  logic                    fetching;
  logic [SUM_W-1:0]        credit_sum;
  logic                    accept;
  logic                    resp;
  logic                    redirect;
  logic                    keep;
  logic                    pop;
  logic [INF_W-1:0]        inflight_next;
  logic [DATA_WIDTH-1:0]   redirect_target;

  // Credits count both queued and in-flight words so a response always has a slot,
  // even one that will later be dropped.
  assign fetching        = (state_reg == FETCH);
  assign credit_sum      = SUM_W'(count_reg) + SUM_W'(inflight_reg);
  assign imem_req_o      = fetching && (credit_sum < SUM_W'(QUEUE_DEPTH))
                           && (inflight_reg < INF_W'(MAX_OUTSTANDING));
  assign imem_addr_o     = fetch_pc_reg & ALIGN_MASK;
  assign accept          = imem_req_o & imem_ready_i;
  assign resp            = fetching & imem_rvalid_i;
  assign redirect        = fetching & redirect_i;
  assign keep            = resp & (drop_reg == '0) & ~redirect;
  assign pop             = instr_valid_o & instr_ready_i & ~redirect;
  assign inflight_next   = inflight_reg + INF_W'(accept) - INF_W'(resp);
  assign redirect_target = redirect_pc_i & ALIGN_MASK;

  assign instr_valid_o     = (count_reg != '0);
  assign instr_o           = instr_valid_o ? q_instr[head_reg] : NOP_INSTR;
  assign instr_pc_o        = instr_valid_o ? q_pc[head_reg] : ret_pc_reg;
  assign instr_pc_plus_4_o = instr_pc_o + WORD_STEP;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      ret_pc_reg   <= RESET_PC;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      inflight_reg <= '0;
      drop_reg     <= '0;
    end else begin
      state_reg <= FETCH;
      if (fetching) begin
        inflight_reg <= inflight_next;
        if (redirect) begin
          // Everything still in flight belongs to the old path and must be squashed.
          fetch_pc_reg <= redirect_target;
          ret_pc_reg   <= redirect_target;
          head_reg     <= '0;
          tail_reg     <= '0;
          count_reg    <= '0;
          drop_reg     <= inflight_next;
        end else begin
          if (accept)
            fetch_pc_reg <= fetch_pc_reg + WORD_STEP;
          if (resp && (drop_reg != '0))
            drop_reg <= drop_reg - INF_W'(1);
          if (keep) begin
            tail_reg   <= tail_reg + PTR_W'(1);
            ret_pc_reg <= ret_pc_reg + WORD_STEP;
          end
          if (pop)
            head_reg <= head_reg + PTR_W'(1);
          count_reg <= count_reg + CNT_W'(keep) - CNT_W'(pop);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && keep) begin
      q_instr[tail_reg] <= imem_rdata_i;
      q_pc[tail_reg]    <= ret_pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && fetching) begin
      assert (!(imem_rvalid_i && (inflight_reg == '0)));
      assert (drop_reg <= inflight_reg);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle-accurate vector table, then a fixed-latency
// memory model drives fill, latency, redirect and mid-stream reset sequences.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] D   = 32'h1000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;
  logic        instr_ready;

  logic        use_model;
  logic        t_rvalid;
  logic [31:0] t_rdata;
  int          lat;
  logic        pv [4];
  logic [31:0] pa [4];

  int          n_cmp;
  int          n_fail;
  int          n_acc;
  int          n_rv;
  int          max_inf;
  logic        mon_en;
  logic [31:0] exp_pop;

  fetch_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .imem_req_o        (imem_req),
    .imem_addr_o       (imem_addr),
    .imem_ready_i      (imem_ready),
    .imem_rvalid_i     (imem_rvalid),
    .imem_rdata_i      (imem_rdata),
    .redirect_i        (redirect),
    .redirect_pc_i     (redirect_pc),
    .instr_valid_o     (instr_valid),
    .instr_o           (instr),
    .instr_pc_o        (instr_pc),
    .instr_pc_plus_4_o (instr_pc4),
    .instr_ready_i     (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-latency in-order memory: data word is D | address.
  assign imem_rvalid = use_model ? pv[0] : t_rvalid;
  assign imem_rdata  = use_model ? (D | pa[0]) : t_rdata;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      pv[i] <= pv[i+1];
      pa[i] <= pa[i+1];
    end
    pv[3] <= 1'b0;
    if (!rst_n || !use_model) begin
      for (int i = 0; i < 4; i++) pv[i] <= 1'b0;
    end else if (imem_req && imem_ready) begin
      pv[lat-1] <= 1'b1;
      pa[lat-1] <= imem_addr;
    end
  end

  typedef struct {
    logic        rst_n;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        iready;
    logic        chk;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: account for the transactions this cycle commits, then advance.
  task automatic tick();
    if (rst_n && imem_req && imem_ready) n_acc++;
    if (rst_n && imem_rvalid) n_rv++;
    if (n_acc - n_rv > max_inf) max_inf = n_acc - n_rv;
    if (mon_en && rst_n && instr_valid && instr_ready && !redirect) begin
      check("pop_pc", instr_pc, exp_pop);
      check("pop_instr", instr, D | exp_pop);
      check("pop_pc4", instr_pc4, exp_pop + 32'd4);
      $display("pop pc=%h instr=%h", instr_pc, instr);
      exp_pop = exp_pop + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    check({tag, "_instr"}, instr, NOP);
    check({tag, "_pc"}, instr_pc, 32'h0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    tick();
    check_reset_outputs(tag);
    rst_n = 1'b1;
    tick();
    n_acc = 0;
    n_rv = 0;
    max_inf = 0;
  endtask

  vec_t vecs [17];
  bit   found;

  initial begin
    n_cmp = 0; n_fail = 0; n_acc = 0; n_rv = 0; max_inf = 0;
    mon_en = 1'b0; exp_pop = '0; use_model = 1'b0; lat = 1;
    rst_n = 1'b0; imem_ready = 1'b0; t_rvalid = 1'b0; t_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

    //          rst ry rv rdata            rd rpc        ir  ck req addr       vl instr      pc
    vecs[0]  = '{0, 0, 0, 32'h0,           0, 32'h0,     0,  0, 0, 32'h0,      0, NOP,       32'h0};
    vecs[1]  = '{0, 0, 0, 32'h0,           0, 32'h0,     0,  1, 0, 32'h0,      0, NOP,       32'h0};
    vecs[2]  = '{1, 1, 0, 32'h0,           1, 32'h40,    1,  1, 0, 32'h0,      0, NOP,       32'h0};
    vecs[3]  = '{1, 1, 0, 32'h0,           0, 32'h0,     1,  1, 1, 32'h0,      0, NOP,       32'h0};
    vecs[4]  = '{1, 1, 1, D|32'h0,         0, 32'h0,     1,  1, 1, 32'h4,      0, NOP,       32'h0};
    vecs[5]  = '{1, 1, 1, D|32'h4,         0, 32'h0,     1,  1, 1, 32'h8,      1, D|32'h0,   32'h0};
    vecs[6]  = '{1, 1, 1, D|32'h8,         0, 32'h0,     1,  1, 1, 32'hC,      1, D|32'h4,   32'h4};
    vecs[7]  = '{1, 0, 1, D|32'hC,         0, 32'h0,     1,  1, 1, 32'h10,     1, D|32'h8,   32'h8};
    vecs[8]  = '{1, 1, 0, 32'h0,           0, 32'h0,     1,  1, 1, 32'h10,     1, D|32'hC,   32'hC};
    vecs[9]  = '{1, 1, 0, 32'h0,           0, 32'h0,     1,  1, 1, 32'h14,     0, NOP,       32'h10};
    vecs[10] = '{1, 1, 0, 32'h0,           0, 32'h0,     1,  1, 0, 32'h18,     0, NOP,       32'h10};
    vecs[11] = '{1, 1, 0, 32'h0,           1, 32'h103,   1,  1, 0, 32'h18,     0, NOP,       32'h10};
    vecs[12] = '{1, 1, 1, 32'hDEAD_0010,   0, 32'h0,     1,  1, 0, 32'h100,    0, NOP,       32'h100};
    vecs[13] = '{1, 1, 1, 32'hDEAD_0014,   0, 32'h0,     1,  1, 1, 32'h100,    0, NOP,       32'h100};
    vecs[14] = '{1, 0, 1, D|32'h100,       0, 32'h0,     1,  1, 1, 32'h104,    0, NOP,       32'h100};
    vecs[15] = '{1, 0, 0, 32'h0,           0, 32'h0,     1,  1, 1, 32'h104,    1, D|32'h100, 32'h100};
    vecs[16] = '{1, 0, 0, 32'h0,           0, 32'h0,     1,  1, 1, 32'h104,    0, NOP,       32'h104};

    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      rst_n       = vecs[i].rst_n;
      imem_ready  = vecs[i].ready;
      t_rvalid    = vecs[i].rvalid;
      t_rdata     = vecs[i].rdata;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      instr_ready = vecs[i].iready;
      if (vecs[i].chk) begin
        check($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
        check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
        check($sformatf("v%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
        check($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
        check($sformatf("v%0d_pc", i), instr_pc, vecs[i].e_pc);
        check($sformatf("v%0d_pc4", i), instr_pc4, vecs[i].e_pc + 32'd4);
      end
      $display("vec %0d req=%0b addr=%h valid=%0b instr=%h pc=%h", i, imem_req, imem_addr,
               instr_valid, instr, instr_pc);
      tick();
    end
    redirect = 1'b0; t_rvalid = 1'b0;

    // Fill: decode stalled, immediate responses.
    use_model = 1'b1; mon_en = 1'b1; lat = 1; imem_ready = 1'b1; instr_ready = 1'b0;
    do_reset("b_rst");
    exp_pop = 32'h0;
    repeat (12) tick();
    check("b_full_req", {31'b0, imem_req}, 32'd0);
    check("b_full_valid", {31'b0, instr_valid}, 32'd1);
    check("b_full_accepts", n_acc, 4);
    check("b_full_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    repeat (10) tick();
    check("b_one_more_accepts", n_acc, 5);
    check("b_refill_req", {31'b0, imem_req}, 32'd0);
    check("b_refill_head_pc", instr_pc, 32'h4);
    check("b_refill_addr", imem_addr, 32'h14);

    // Latency 3: in-flight count saturates at the outstanding limit.
    lat = 3; instr_ready = 1'b1;
    do_reset("c_rst");
    exp_pop = 32'h0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (imem_rvalid) begin found = 1'b1; break; end
      tick();
    end
    check("c_first_rvalid_seen", {31'b0, found}, 32'd1);
    check("c_accepts_before_rvalid", n_acc, 2);
    repeat (30) tick();
    check("c_max_inflight", max_inf, 2);
    check("c_progress", {31'b0, exp_pop >= 32'h20}, 32'd1);

    // Redirect coinciding with pop, response and accept.
    lat = 1;
    do_reset("d1_rst");
    exp_pop = 32'h0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (imem_req && imem_rvalid && instr_valid) begin found = 1'b1; break; end
      tick();
    end
    check("d1_condition_seen", {31'b0, found}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect = 1'b0;
    exp_pop = 32'h200;
    check("d1_valid_after", {31'b0, instr_valid}, 32'd0);
    check("d1_addr_after", imem_addr, 32'h200);
    check("d1_pc_after", instr_pc, 32'h200);
    check("d1_instr_after", instr, NOP);
    check("d1_req_after", {31'b0, imem_req}, 32'd1);
    repeat (12) tick();
    check("d1_progress", {31'b0, exp_pop >= 32'h210}, 32'd1);

    // Redirect with an accept and two requests left to squash.
    lat = 3;
    do_reset("d2_rst");
    exp_pop = 32'h0;
    tick();
    check("d2_req_before", {31'b0, imem_req}, 32'd1);
    check("d2_rvalid_before", {31'b0, imem_rvalid}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    exp_pop = 32'h300;
    check("d2_addr_after", imem_addr, 32'h300);
    check("d2_valid_after", {31'b0, instr_valid}, 32'd0);
    check("d2_req_after", {31'b0, imem_req}, 32'd0);
    repeat (30) tick();
    check("d2_progress", {31'b0, exp_pop >= 32'h310}, 32'd1);

    // Reset mid-stream while a response is arriving.
    lat = 1;
    do_reset("e_rst0");
    exp_pop = 32'h0;
    repeat (6) tick();
    check("e_resp_pending", {31'b0, imem_rvalid}, 32'd1);
    do_reset("e_rst_mid");
    exp_pop = 32'h0;
    check("e_first_addr", imem_addr, 32'h0);
    check("e_first_req", {31'b0, imem_req}, 32'd1);
    repeat (10) tick();
    check("e_progress", {31'b0, exp_pop >= 32'h10}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
